// File: rtl/uart_tx_pkg.sv
// Shared constants and one-hot state encodings for the UART transmitter.
// The parity stage is compiled in only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_START  = 5'b00010;
    localparam logic [4:0] ST_DATA   = 5'b00100;
    localparam logic [4:0] ST_PARITY = 5'b01000;
    localparam logic [4:0] ST_STOP   = 5'b10000;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side handshake and status bundle of the UART transmitter.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [UART_DATA_BITS-1:0] data_i;
    logic                      TX_valid_i;
    logic                      TX_ready_o;
    logic                      TX_busy_o;
    logic                      TX_done_o;

    modport master (
        output data_i, TX_valid_i,
        input  TX_ready_o, TX_busy_o, TX_done_o
    );

    modport slave (
        input  data_i, TX_valid_i,
        output TX_ready_o, TX_busy_o, TX_done_o
    );

endinterface

// File: rtl/uart_tx_buf.sv
// One-entry holding register between the producer and the transmit shifter.
module uart_tx_buf
    import uart_tx_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [UART_DATA_BITS-1:0] wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      rd_free,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      full
);

    logic                      full_q;
    logic [UART_DATA_BITS-1:0] data_q;

    assign wr_ready = !full_q;
    assign rd_data  = data_q;
    assign full     = full_q;

    // A new write wins over a free so a same-cycle refill never loses the byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_valid && wr_ready) begin
            full_q <= 1'b1;
            data_q <= wr_data;
        end else if (rd_free) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic      clk_i,
    input  logic      rst_i,
    uart_tx_if.slave  bus,
    output logic      TxD_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);

    logic [4:0]                state;
    logic [CW-1:0]             bit_cnt;
    logic [2:0]                data_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] buf_data;
    logic                      buf_full;
    logic                      buf_free;
    logic                      bit_end;
`ifdef UART_TX_PARITY_EN
    logic                      par_q;
`endif

    assign bit_end  = (bit_cnt == BIT_LAST);
    assign buf_free = buf_full && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

    assign bus.TX_busy_o = (state != ST_IDLE);
    assign bus.TX_done_o = (state == ST_STOP) && bit_end;

    uart_tx_buf u_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_data  (bus.data_i),
        .wr_valid (bus.TX_valid_i),
        .wr_ready (bus.TX_ready_o),
        .rd_free  (buf_free),
        .rd_data  (buf_data),
        .full     (buf_full)
    );

    // A frame starts from idle or straight out of a finished stop bit, so
    // back-to-back bytes leave no idle gap on the line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            data_cnt <= '0;
            shreg    <= '0;
            TxD_o    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (buf_free) begin
            state    <= ST_START;
            shreg    <= buf_data;
            bit_cnt  <= '0;
            TxD_o    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= even_parity(buf_data);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    TxD_o <= 1'b1;
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        bit_cnt  <= '0;
                        data_cnt <= '0;
                        TxD_o    <= shreg[UART_DATA_BITS-1];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        shreg    <= {shreg[UART_DATA_BITS-2:0], 1'b0};
                        data_cnt <= data_cnt + 1'b1;
                        if (data_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            TxD_o <= par_q;
`else
                            state <= ST_STOP;
                            TxD_o <= 1'b1;
`endif
                        end else begin
                            TxD_o <= shreg[UART_DATA_BITS-2];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                        TxD_o   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        TxD_o   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    TxD_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx against a frame-timeline reference model.
// Frame layout follows UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic clk_i = 1'b0;
    logic rst_i;
    logic TxD_o;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave),
        .TxD_o (TxD_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passed = 0;

    // Reference model: each frame is a start edge plus a byte; the line is
    // a pure function of how far into its frame the current edge is.
    int         edge_no = 0;
    bit         cur_active = 0;
    int         cur_start = 0;
    logic [7:0] cur_byte = '0;
    bit         pend_valid = 0;
    logic [7:0] pend_byte = '0;
    bit         last_acc = 0;
    logic [7:0] tx_q[$];

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[8 - idx];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic rst, input logic vld, input logic [7:0] d);
        int k;
        logic exp_txd;
        rst_i          = rst;
        bus.TX_valid_i = vld;
        bus.data_i     = d;
        @(posedge clk_i);
        edge_no++;
        last_acc = 1'b0;
        if (rst) begin
            cur_active = 0;
            pend_valid = 0;
        end else begin
            last_acc = vld && !pend_valid;
            if (cur_active && edge_no == cur_start + FL) cur_active = 0;
            if (!cur_active && pend_valid) begin
                cur_active = 1;
                cur_start  = edge_no;
                cur_byte   = pend_byte;
                pend_valid = 0;
            end
            if (last_acc) begin
                pend_valid = 1;
                pend_byte  = d;
            end
        end
        k       = edge_no - cur_start;
        exp_txd = cur_active ? frameBit(cur_byte, k / CPB) : 1'b1;
        #1;
        checkOutput("txd",   {7'b0, TxD_o},          {7'b0, exp_txd});
        checkOutput("busy",  {7'b0, bus.TX_busy_o},  {7'b0, cur_active});
        checkOutput("done",  {7'b0, bus.TX_done_o},  {7'b0, (cur_active && k == FL - 1)});
        checkOutput("ready", {7'b0, bus.TX_ready_o}, {7'b0, !pend_valid});
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (tx_q.size() > 0) applyStimulus(1'b0, 1'b1, tx_q[0]);
            else applyStimulus(1'b0, 1'b0, 8'($urandom));
            if (last_acc) void'(tx_q.pop_front());
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        bus.TX_valid_i = 1'b0;
        bus.data_i     = '0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);

        tx_q.push_back(8'hA5);
        runCycles(FL + 10);

        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h3C);
        runCycles(2 * FL + 4 * CPB + 5);
        applyStimulus(1'b1, 1'b0, 8'h00);

        tx_q.push_back(8'h81);
        runCycles(FL + 10);

        for (int i = 0; i < 4000; i++) begin
            if (tx_q.size() < 2 && $urandom_range(0, 39) == 0) tx_q.push_back(8'($urandom));
            if ($urandom_range(0, 1499) == 0) applyStimulus(1'b1, 1'b0, 8'h00);
            else runCycles(1);
        end
        tx_q.delete();
        runCycles(2 * FL + 5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
